uart_frame_ctrl: RTL and testbench

UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_timeout_cnt.sv | 31 +++
 rtl/uart_frame_ctrl.sv | 152 +++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: state and error-code types shared by the UART frame controller.
// Also holds the default start-of-frame marker.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_HOLD
    } state_t;

    typedef enum logic [1:0] {
        ERR_TIMEOUT = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_OVERRUN = 2'd3
    } err_code_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_timeout_cnt.sv
// uart_timeout_cnt: loadable down counter; expire fires on the LIMIT-th
// enabled cycle after the last load.
module uart_timeout_cnt #(
    parameter int LIMIT = 34700
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LOAD_VAL = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    // A load in the same cycle always wins over expiry.
    assign expire = en && !load && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: parses SOF/CMD/LEN/DATA[/CSUM] byte frames from a UART.
// Optional checksum byte is enabled by defining UART_FRAME_CHECKSUM_EN.
module uart_frame_ctrl
    import uart_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT,
    parameter int         MAX_LEN     = 16,
    parameter int         TIMEOUT_CYC = 34700
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         frame_valid,
    input  logic         frame_ready,
    output logic [7:0]   cmd,
    output logic [4:0]   len,
    output logic [127:0] payload,
    output logic         err,
    output logic [1:0]   err_code
);

    state_t    state, state_n;
    err_code_t code_n;
    logic      err_n;
    logic      cap_cmd, cap_len, cap_data;
    logic      active, expire;
    logic      len_ok, last_byte;
    logic [3:0] idx;

    assign active = (state == S_CMD) || (state == S_LEN) ||
                    (state == S_DATA) || (state == S_CSUM);
    assign len_ok = (rx_data != 8'd0) && (rx_data <= 8'(MAX_LEN));
    assign last_byte = ({1'b0, idx} == len - 5'd1);
    assign frame_valid = (state == S_HOLD);

    uart_timeout_cnt #(
        .LIMIT (TIMEOUT_CYC)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .load   (rx_valid),
        .en     (active),
        .expire (expire)
    );

`ifdef UART_FRAME_CHECKSUM_EN
    // Unused payload bytes are zero, so folding all 16 is exact.
    logic [7:0] csum;
    always_comb begin
        csum = cmd ^ {3'b000, len};
        for (int i = 0; i < 16; i++) begin
            csum = csum ^ payload[8*i +: 8];
        end
    end
`endif

    always_comb begin
        state_n  = state;
        err_n    = 1'b0;
        code_n   = ERR_TIMEOUT;
        cap_cmd  = 1'b0;
        cap_len  = 1'b0;
        cap_data = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (rx_valid && rx_data == SOF_BYTE) state_n = S_CMD;
            end
            S_CMD: begin
                if (rx_valid) begin
                    cap_cmd = 1'b1;
                    state_n = S_LEN;
                end
            end
            S_LEN: begin
                if (rx_valid && len_ok) begin
                    cap_len = 1'b1;
                    state_n = S_DATA;
                end else if (rx_valid) begin
                    err_n   = 1'b1;
                    code_n  = ERR_LEN;
                    state_n = S_IDLE;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    cap_data = 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
                    if (last_byte) state_n = S_CSUM;
`else
                    if (last_byte) state_n = S_HOLD;
`endif
                end
            end
`ifdef UART_FRAME_CHECKSUM_EN
            S_CSUM: begin
                if (rx_valid && rx_data == csum) begin
                    state_n = S_HOLD;
                end else if (rx_valid) begin
                    err_n   = 1'b1;
                    code_n  = ERR_CSUM;
                    state_n = S_IDLE;
                end
            end
`endif
            S_HOLD: begin
                if (rx_valid) begin
                    err_n  = 1'b1;
                    code_n = ERR_OVERRUN;
                end
                if (frame_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        // expire implies no byte this cycle, so it never masks another cause
        if (expire) begin
            err_n   = 1'b1;
            code_n  = ERR_TIMEOUT;
            state_n = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd      <= '0;
            len      <= '0;
            payload  <= '0;
            idx      <= '0;
            err      <= 1'b0;
            err_code <= '0;
        end else begin
            err <= err_n;
            if (err_n) err_code <= code_n;
            if (cap_cmd) cmd <= rx_data;
            if (cap_len) begin
                len     <= rx_data[4:0];
                payload <= '0;
                idx     <= '0;
            end
            if (cap_data) begin
                payload[8*idx +: 8] <= rx_data;
                idx <= idx + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: random byte streams, frame-level reference model and
// an event scoreboard drained by an independent monitor.
module tb_uart_frame_ctrl;

    localparam logic [7:0] SOF = 8'hA5;
    localparam int MAX = 16;
    localparam int T = 20;
`ifdef UART_FRAME_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         frame_valid;
    logic         frame_ready;
    logic [7:0]   cmd;
    logic [4:0]   len;
    logic [127:0] payload;
    logic         err;
    logic [1:0]   err_code;

    always #5 clk = ~clk;

    uart_frame_ctrl #(
        .SOF_BYTE    (SOF),
        .MAX_LEN     (MAX),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .cmd         (cmd),
        .len         (len),
        .payload     (payload),
        .err         (err),
        .err_code    (err_code)
    );

    typedef struct {
        bit           is_frame;
        logic [1:0]   code;
        logic [7:0]   cmd;
        logic [4:0]   len;
        logic [127:0] pl;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_e;
    ev_t        m_frame;
    logic [7:0] seg_b[$];
    int         seg_g[$];
    bit         m_hold;
    bit         m_tail;
    int         m_done;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] a,
                       input logic [127:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    task automatic push_err(input logic [1:0] c);
        ev_t e;
        e.is_frame = 1'b0;
        e.code = c;
        e.cmd = '0;
        e.len = '0;
        e.pl = '0;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data = 8'($urandom);
    endtask

    function automatic int gap(input bit noisy);
        int r;
        r = $urandom_range(0, 15);
        if (r < 14) return r % 3;
        if (r == 14 || !noisy) return T - 1;
        return T;
    endfunction

    task automatic add(input logic [7:0] b, input bit noisy);
        seg_b.push_back(b);
        seg_g.push_back(gap(noisy));
    endtask

    task automatic add0(input logic [7:0] b);
        seg_b.push_back(b);
        seg_g.push_back(0);
    endtask

    // Frame-level view: bytes after SOF are collected and judged by size.
    task automatic model_seg();
        logic [7:0] fb[$];
        logic [7:0] b, x;
        bit act;
        int L;
        act = 1'b0;
        m_hold = 1'b0;
        m_tail = 1'b0;
        m_done = -1;
        for (int i = 0; i < seg_b.size(); i++) begin
            b = seg_b[i];
            if (m_hold) begin
                push_err(2'd3);
                continue;
            end
            if (act && seg_g[i] >= T) begin
                push_err(2'd0);
                act = 1'b0;
            end
            if (!act) begin
                if (b == SOF) begin
                    act = 1'b1;
                    fb.delete();
                end
                continue;
            end
            fb.push_back(b);
            if (fb.size() == 2 && (b == 8'd0 || b > MAX)) begin
                push_err(2'd1);
                act = 1'b0;
                continue;
            end
            if (fb.size() < 2) continue;
            L = int'(fb[1]);
            if (fb.size() != 2 + L + CS) continue;
            act = 1'b0;
            x = '0;
            for (int j = 0; j < 2 + L; j++) x ^= fb[j];
            if (CS != 0 && fb[fb.size()-1] != x) begin
                push_err(2'd2);
            end else begin
                m_hold = 1'b1;
                m_done = i;
                m_frame.is_frame = 1'b1;
                m_frame.code = '0;
                m_frame.cmd = fb[0];
                m_frame.len = 5'(L);
                m_frame.pl = '0;
                for (int j = 0; j < L; j++) m_frame.pl[8*j +: 8] = fb[2+j];
            end
        end
        if (act) begin
            m_tail = 1'b1;
            push_err(2'd0);
        end
    endtask

    task automatic build(input bit noisy);
        int n, L, k;
        logic [7:0] b, x;
        seg_b.delete();
        seg_g.delete();
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (b == SOF) b = 8'h00;
            add(b, noisy);
        end
        L = $urandom_range(1, MAX);
        b = 8'($urandom);
        add(SOF, noisy);
        add(b, noisy);
        x = b ^ 8'(L);
        add(8'(L), noisy);
        for (int i = 0; i < L; i++) begin
            b = 8'($urandom);
            x ^= b;
            add(b, noisy);
        end
        if (CS != 0) add(x, noisy);
        if (noisy) begin
            k = $urandom_range(0, 3);
            case (k)
                0: seg_b[$urandom_range(n + 1, seg_b.size() - 1)] =
                       8'($urandom);
                1: seg_b[n + 2] = ($urandom_range(0, 1) != 0) ? 8'h00 :
                       8'($urandom_range(MAX + 1, 255));
                2: repeat ($urandom_range(1, 3)) begin
                       void'(seg_b.pop_back());
                       void'(seg_g.pop_back());
                   end
                default: repeat ($urandom_range(1, 2)) add(8'($urandom), 1'b1);
            endcase
        end
    endtask

    task automatic play_seg();
        for (int i = 0; i < seg_b.size(); i++) begin
            idle(seg_g[i]);
            send(seg_b[i]);
            if (i == m_done) chk("fv_after_last", frame_valid, 1'b1);
        end
        if (m_tail) idle(T);
        idle(2);
        if (!m_hold) chk("fv_no_frame", frame_valid, 1'b0);
    endtask

    task automatic hold_phase(input int n_over, input int sim);
        if (!m_hold) return;
        for (int k = 0; k < n_over; k++) push_err(2'd3);
        exp_q.push_back(m_frame);
        if (sim != 0) push_err(2'd3);
        if ($urandom_range(0, 7) == 0) idle(T + 2);
        else idle($urandom_range(0, 2));
        for (int k = 0; k < n_over; k++) send(8'($urandom));
        idle(1);
        chk("hold_cmd", cmd, m_frame.cmd);
        chk("hold_len", len, m_frame.len);
        chk("hold_payload", payload, m_frame.pl);
        frame_ready = 1'b1;
        if (sim != 0) begin
            rx_valid = 1'b1;
            rx_data = 8'($urandom);
        end
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
        rx_valid = 1'b0;
        chk("fv_after_hs", frame_valid, 1'b0);
        idle(2);
    endtask

    task automatic run_seg(input int n_over, input int sim);
        model_seg();
        play_seg();
        hold_phase(n_over, sim);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (err) begin
                if (exp_q.size() == 0 || exp_q[0].is_frame) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL err_unexpected: got err code %0d want none",
                             err_code);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("err_code", err_code, mon_e.code);
                end
            end
            if (frame_valid && frame_ready) begin
                if (exp_q.size() == 0 || !exp_q[0].is_frame) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL frame_unexpected: got cmd %0h want none",
                             cmd);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("frame_cmd", cmd, mon_e.cmd);
                    chk("frame_len", len, mon_e.len);
                    chk("frame_payload", payload, mon_e.pl);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = '0;
        frame_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fv", frame_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_code", err_code, 2'd0);
        chk("rst_cmd", cmd, 8'd0);
        chk("rst_len", len, 5'd0);
        chk("rst_payload", payload, 128'd0);
        rst = 1'b0;
        idle(2);

        seg_b.delete(); seg_g.delete();
        add0(SOF); add0(8'h10); add0(8'h02); add0(8'h11); add0(8'h22);
        if (CS != 0) add0(8'h21);
        model_seg();
        play_seg();
        chk("d_cmd", cmd, 8'h10);
        chk("d_len", len, 5'd2);
        chk("d_payload", payload, 128'h2211);
        hold_phase(0, 0);

        seg_b.delete(); seg_g.delete();
        add0(SOF); add0(8'h10); add0(8'h00);
        run_seg(0, 0);

        if (CS != 0) begin
            seg_b.delete(); seg_g.delete();
            add0(SOF); add0(8'h10); add0(8'h01); add0(8'h33); add0(8'h00);
            run_seg(0, 0);
        end

        seg_b.delete(); seg_g.delete();
        add0(SOF); add0(8'h10);
        run_seg(0, 0);
        build(1'b0);
        run_seg(0, 0);

        build(1'b0);
        seg_g = '{default: 0};
        model_seg();
        play_seg();
        hold_phase(1, 0);

        send(SOF); send(8'h42); send(8'h08);
        send(8'h01); send(8'h02); send(8'h03);
        rst = 1'b1;
        rx_valid = 1'b1;
        rx_data = SOF;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rx_valid = 1'b0;
        chk("mid_rst_fv", frame_valid, 1'b0);
        chk("mid_rst_cmd", cmd, 8'd0);
        chk("mid_rst_len", len, 5'd0);
        chk("mid_rst_payload", payload, 128'd0);
        chk("mid_rst_err", err, 1'b0);
        idle(2);
        chk("mid_rst_err_late", err, 1'b0);
        build(1'b0);
        run_seg(0, 0);

        for (int s = 0; s < 70; s++) begin
            build($urandom_range(0, 1) != 0);
            run_seg($urandom_range(0, 2), $urandom_range(0, 1));
        end

        for (int k = 0; k < 50 && exp_q.size() != 0; k++) idle(1);
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
